// File: rtl/answer_slot_mux.sv
// rtl/answer_slot_mux.sv - request-counting answer mux: main data except in one aux slot, aux group rotates per frame
// Optional feature macro: FRAME_SYNC_EN (adds synchronised frame_sync restart input)
module answer_slot_mux #(
    parameter int DW        = 8,
    parameter int SLOT_W    = 7,
    parameter int FRAME_LEN = 128,
    parameter int AUX_SLOT  = 122,
    parameter int SEL_W     = 3,
    parameter int CH_LOG2   = 2,
    parameter int NUM_GRP   = 32,
    parameter int GRP_W     = 5,
    parameter int AW        = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [SEL_W-1:0]  sel,
    input  logic [DW-1:0]     data_aux,
    input  logic [DW-1:0]     data_main,
`ifdef FRAME_SYNC_EN
    input  logic              frame_sync,
`endif
    output logic [DW-1:0]     data_tx,
    output logic [AW-1:0]     addr_aux,
    output logic [SLOT_W-1:0] slot,
    output logic              aux_active,
    output logic              frame_wrap
);

    if (AUX_SLOT >= FRAME_LEN) begin : g_bad_aux_slot
        $error("answer_slot_mux: AUX_SLOT must be below FRAME_LEN");
    end
    if (NUM_GRP > 2**GRP_W) begin : g_bad_grp_w
        $error("answer_slot_mux: GRP_W too narrow for NUM_GRP");
    end

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(FRAME_LEN - 1);
    localparam logic [SLOT_W-1:0] SLOT_AUX  = SLOT_W'(AUX_SLOT);
    // grp advances in the slot right after the aux slot, so the new group is ready next frame
    localparam logic [SLOT_W-1:0] SLOT_STEP = SLOT_W'((AUX_SLOT + 1) % FRAME_LEN);
    localparam logic [GRP_W-1:0]  GRP_LAST  = GRP_W'(NUM_GRP - 1);

    typedef enum logic [1:0] {IDLE, CHECK, HOLD} state_t;

    state_t            state, state_next;
    logic [1:0]        req_sync;
    logic              req_s;
    logic [GRP_W-1:0]  grp, grp_next;
    logic [SLOT_W-1:0] slot_next;
    logic              wrap_next;

    assign req_s = req_sync[1];

`ifdef FRAME_SYNC_EN
    // third stage holds the previous synchronised level for edge detection
    logic [2:0] fs_sync;
    logic       fs_rise;

    assign fs_rise = fs_sync[1] & ~fs_sync[2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) fs_sync <= '0;
        else      fs_sync <= {fs_sync[1:0], frame_sync};
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_sync   <= '0;
            state      <= IDLE;
            slot       <= '0;
            grp        <= '0;
            frame_wrap <= 1'b0;
        end else begin
            req_sync   <= {req_sync[0], req};
            state      <= state_next;
            slot       <= slot_next;
            grp        <= grp_next;
            frame_wrap <= wrap_next;
        end
    end

    always_comb begin
        state_next = state;
        slot_next  = slot;
        grp_next   = grp;
        wrap_next  = 1'b0;
        case (state)
            IDLE: begin
                if (req_s) begin
                    slot_next  = (slot == SLOT_LAST) ? '0 : slot + 1'b1;
                    wrap_next  = (slot == SLOT_LAST);
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (slot == SLOT_STEP)
                    grp_next = (grp == GRP_LAST) ? '0 : grp + 1'b1;
                state_next = HOLD;
            end
            HOLD: begin
                if (!req_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
`ifdef FRAME_SYNC_EN
        // frame restart wins; parking in HOLD drops any coincident request
        if (fs_rise) begin
            slot_next  = '0;
            grp_next   = grp;
            wrap_next  = 1'b0;
            state_next = HOLD;
        end
`endif
    end

    assign aux_active = (slot == SLOT_AUX);
    assign data_tx    = aux_active ? data_aux : data_main;
    assign addr_aux   = AW'(sel) + AW'(32'(grp) << CH_LOG2);

endmodule

// File: tb/tb_answer_slot_mux.sv
// tb/tb_answer_slot_mux.sv - directed self-checking bench for answer_slot_mux
module tb_answer_slot_mux;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req = 1'b0;
    logic [2:0] sel = 3'd2;
    logic [7:0] data_aux  = 8'hA5;
    logic [7:0] data_main = 8'h3C;
`ifdef FRAME_SYNC_EN
    logic       frame_sync = 1'b0;
`endif
    logic [7:0] data_tx;
    logic [6:0] addr_aux;
    logic [6:0] slot;
    logic       aux_active;
    logic       frame_wrap;

    int checks   = 0;
    int failures = 0;
    int wraps    = 0;

    answer_slot_mux dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .sel        (sel),
        .data_aux   (data_aux),
        .data_main  (data_main),
`ifdef FRAME_SYNC_EN
        .frame_sync (frame_sync),
`endif
        .data_tx    (data_tx),
        .addr_aux   (addr_aux),
        .slot       (slot),
        .aux_active (aux_active),
        .frame_wrap (frame_wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one request: 4 clocks high, 4 low; frame_wrap is sampled on every negedge
    task automatic pulse();
        @(negedge clk);
        req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (frame_wrap) wraps++;
        end
        req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (frame_wrap) wraps++;
        end
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) pulse();
    endtask

    initial begin
        #1;
        check("reset_slot", 32'(slot), 32'd0);
        check("reset_data_tx", 32'(data_tx), 32'h3C);
        check("reset_addr_aux", 32'(addr_aux), 32'd2);
        check("reset_aux_active", 32'(aux_active), 32'd0);
        check("reset_frame_wrap", 32'(frame_wrap), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        pulses(3);
        check("t1_slot", 32'(slot), 32'd3);
        check("t1_addr_grp0", 32'(addr_aux), 32'd2);
        check("t1_data_tx", 32'(data_tx), 32'h3C);

        pulses(119);
        check("t2_slot122", 32'(slot), 32'd122);
        check("t2_aux_active", 32'(aux_active), 32'd1);
        check("t2_data_aux", 32'(data_tx), 32'hA5);
        check("t2_addr_still_grp0", 32'(addr_aux), 32'd2);
        pulse();
        check("t2_slot123", 32'(slot), 32'd123);
        check("t2_aux_off", 32'(aux_active), 32'd0);
        check("t2_data_main", 32'(data_tx), 32'h3C);
        check("t2_addr_grp1", 32'(addr_aux), 32'd6);

        pulses(4);
        check("t3_slot127", 32'(slot), 32'd127);
        check("t3_no_wrap_yet", 32'(wraps), 32'd0);
        pulse();
        check("t3_slot_wrapped", 32'(slot), 32'd0);
        check("t3_wrap_one_cycle", 32'(wraps), 32'd1);
        check("t3_addr_grp1_kept", 32'(addr_aux), 32'd6);

        wraps = 0;
        pulses(31 * 128);
        check("t3_31_frames_wraps", 32'(wraps), 32'd31);
        check("t3_slot_frame_start", 32'(slot), 32'd0);
        check("t3_grp_back_to_0", 32'(addr_aux), 32'd2);

        @(negedge clk);
        req = 1'b1;
        repeat (50) @(negedge clk);
        check("t4_held_counts_once", 32'(slot), 32'd1);
        rst = 1'b0;
        #1;
        check("t4_rst_slot", 32'(slot), 32'd0);
        check("t4_rst_data_tx", 32'(data_tx), 32'h3C);
        check("t4_rst_addr", 32'(addr_aux), 32'd2);
        check("t4_rst_aux_active", 32'(aux_active), 32'd0);
        check("t4_rst_frame_wrap", 32'(frame_wrap), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        sel = 3'd5;
        repeat (10) @(negedge clk);
        check("t4_recount_after_rst", 32'(slot), 32'd1);
        check("t4_addr_sel5", 32'(addr_aux), 32'd5);
        req = 1'b0;
        repeat (6) @(negedge clk);
        pulse();
        check("t4_next_pulse", 32'(slot), 32'd2);

`ifdef FRAME_SYNC_EN
        pulses(38);
        check("t5_slot40", 32'(slot), 32'd40);
        @(negedge clk);
        req = 1'b1;
        frame_sync = 1'b1;
        repeat (4) @(negedge clk);
        req = 1'b0;
        frame_sync = 1'b0;
        repeat (6) @(negedge clk);
        check("t5_sync_slot0", 32'(slot), 32'd0);
        pulse();
        check("t5_next_req_slot1", 32'(slot), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
